sequential_divider: RTL

Multi-cycle unsigned restoring divider for the Flappy Bird ARMv4 ALU. It is the inverse companion of the combinational add/subtract arithmetic unit: it produces quotient and remainder by repeated trial subtraction, one quotient bit per clock. It sits beside the arithmetic unit and is driven by the ALU control through a start/done handshake.

---
 rtl/alu_pkg.sv | 12 +
 rtl/sequential_divider_if.sv | 28 ++
 rtl/arithmetic_unit.sv | 21 ++
 rtl/sequential_divider.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Start/done handshake and result bus between the ALU control and the sequential divider.
//   start, dividend, divisor            : request side (driven by the ALU control)
//   busy, done, quotient, remainder,
//   div_by_zero                         : response side (driven by the divider)
interface sequential_divider_if #(
  parameter int unsigned N = alu_pkg::ALU_WIDTH
) ();

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/arithmetic_unit.sv
// Combinational add/subtract unit.
//   a, b : operands
//   sub  : 1 selects a - b (two's complement), 0 selects a + b
//   y    : result
//   cout : carry out (for subtraction, 1 means no borrow)
module arithmetic_unit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y,
  output logic         cout
);

  logic [N-1:0] b_eff;

  assign b_eff     = sub ? ~b : b;
  assign {cout, y} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of sequential_divider_if
//         start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
// A nonzero division spends N cycles in RUN followed by one DONE cycle; a zero
// divisor goes straight to DONE. Requires N >= 2.
module sequential_divider
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  sequential_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(N);

  div_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]   pr_q, pr_d;      // partial remainder, one bit wider for the trial subtract
  logic [N-1:0] dvd_q, dvd_d;    // dividend bits shift out the top, quotient bits shift in below
  logic [N-1:0] dvs_q, dvs_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;

  logic [N:0]   pr_shift;
  logic [N:0]   diff;
  logic         qbit;
  logic         accept;
  logic         unused_cout;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign pr_shift = {pr_q[N-1:0], dvd_q[N-1]};
  // Negative difference (MSB set) means the divisor did not fit: restore.
  assign qbit     = ~diff[N];

  arithmetic_unit #(
    .N (N + 1)
  ) u_trial_sub (
    .a    (pr_shift),
    .b    ({1'b0, dvs_q}),
    .sub  (1'b1),
    .y    (diff),
    .cout (unused_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy        = (state_q == RUN);
    bus.done        = (state_q == DONE);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

  // Datapath next state
  always_comb begin
    cnt_d = cnt_q;
    pr_d  = pr_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvd_d = bus.dividend;
      dvs_d = bus.divisor;
      pr_d  = '0;
      dbz_d = 1'b0;
      cnt_d = CW'(N - 1);
      if (bus.divisor == '0) begin
        quo_d = '1;
        rem_d = bus.dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      pr_d  = qbit ? diff : pr_shift;
      dvd_d = {dvd_q[N-2:0], qbit};
      cnt_d = cnt_q - CW'(1);
      // Published results only change on completion, so they hold through RUN.
      if (cnt_q == '0) begin
        quo_d = {dvd_q[N-2:0], qbit};
        rem_d = pr_d[N-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pr_q  <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pr_q  <= pr_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

endmodule
